// File: rtl/jamma_input_scanner.sv
// Time-multiplexed JAMMA control-input scanner: walks the player-select line, waits for the
// external mux to settle, then latches the synchronised JJOY bus into one register per player.
// Optional per-bit debounce is built when JAMMA_DEBOUNCE_EN is defined.

module jamma_slot #(
  parameter int JOY_W = 8
`ifdef JAMMA_DEBOUNCE_EN
  , parameter int DB_SCANS = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [JOY_W-1:0] data,
  output logic [JOY_W-1:0] joy
);
`ifdef JAMMA_DEBOUNCE_EN
  localparam logic [3:0] DB_LAST = 4'(DB_SCANS - 1);

  // A bit flips only after DB_SCANS consecutive samples that disagree with it.
  for (genvar b = 0; b < JOY_W; b++) begin : g_bit
    logic [3:0] cnt;
    logic       q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        q   <= 1'b1;
      end else if (sample) begin
        if (data[b] == q) begin
          cnt <= '0;
        end else if (cnt >= DB_LAST) begin
          q   <= data[b];
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
    assign joy[b] = q;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         joy <= '1;
    else if (sample) joy <= data;
  end
`endif
endmodule

module jamma_input_scanner #(
  parameter  int NUM_PLAYERS = 2,
  parameter  int JOY_W       = 8,
  parameter  int SETTLE_CYC  = 0,
  parameter  int DB_SCANS    = 3,
  localparam int SEL_W       = (NUM_PLAYERS > 2) ? 2 : 1
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         I_ENA,
  input  logic [JOY_W-1:0]             I_JJOY,
  input  logic [5:0]                   I_LOCAL_JOY,
  output logic [SEL_W-1:0]             O_JSELECT,
  output logic [NUM_PLAYERS*JOY_W-1:0] O_JOY,
  output logic                         O_SCAN_DONE
);
  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || SETTLE_CYC < 0 || SETTLE_CYC > 15 ||
      DB_SCANS < 1 || DB_SCANS > 15 || JOY_W < 6) begin : g_bad_cfg
    $error("jamma_input_scanner: parameter out of range");
  end

  typedef enum logic {ST_SETTLE, ST_SAMPLE} state_t;

  localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_PLAYERS - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] sel;
  logic             sample_now, last_slot, done_q;
  logic [JOY_W-1:0] jjoy_s1, jjoy_s2, local_mask, slot_data;

  // The bus is asynchronous to I_CLK; the settle count is expected to cover these two stages.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      jjoy_s1 <= '1;
      jjoy_s2 <= '1;
    end else if (I_ENA) begin
      jjoy_s1 <= I_JJOY;
      jjoy_s2 <= jjoy_s1;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET)    state <= ST_SETTLE;
    else if (I_ENA) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SETTLE: if (SETTLE_CYC != 0 && cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_SETTLE;
      default:   state_nxt = ST_SETTLE;
    endcase
  end

  // With no settle time the SETTLE state doubles as the sample cycle, one slot per cycle.
  always_comb begin
    sample_now = (state == ST_SAMPLE) || (SETTLE_CYC == 0);
    last_slot  = (sel == SEL_LAST);
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      cnt <= '0;
    end else if (I_ENA) begin
      if (sample_now)               cnt <= '0;
      else if (cnt != SETTLE_LAST)  cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET)                   sel <= '0;
    else if (I_ENA && sample_now)  sel <= last_slot ? '0 : sel + SEL_W'(1);
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) done_q <= 1'b0;
    else         done_q <= I_ENA & sample_now & last_slot;
  end

  always_comb begin
    local_mask      = '1;
    local_mask[5:0] = I_LOCAL_JOY;
    slot_data       = (sel == '0) ? (jjoy_s2 & local_mask) : jjoy_s2;
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_slot
    jamma_slot #(
      .JOY_W(JOY_W)
`ifdef JAMMA_DEBOUNCE_EN
      , .DB_SCANS(DB_SCANS)
`endif
    ) u_slot (
      .clk    (I_CLK),
      .rst    (I_RESET),
      .sample (I_ENA && sample_now && (sel == SEL_W'(p))),
      .data   (slot_data),
      .joy    (O_JOY[p*JOY_W +: JOY_W])
    );
  end

  assign O_JSELECT   = sel;
  assign O_SCAN_DONE = done_q & I_ENA;
endmodule
